// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------------------
// serial_frame_tx
//
// Host-side serial frame transmitter. Accepts one WIDTH-bit word through a
// valid/ready handshake and shifts it out MSB first on a divided serial clock.
// frame_sync marks the first bit period, frame_done pulses once the last bit
// period has completed, and a GAP-period idle interval separates frames.
//
// Parameters:
//   WIDTH  frame length in bits (>= 1)
//   DIV    clk cycles per serial_clk half-period (>= 1)
//   GAP    idle serial_clk periods between frames (>= 0)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   in_data      parallel word, sampled on accept
//   in_valid     source has a word
//   in_ready     transmitter can accept (combinational)
//   serial_data  serial bit, MSB first (registered)
//   serial_clk   generated serial clock, receiver samples on rising edge
//   frame_sync   high for the first bit period of a frame
//   busy         high whenever the transmitter is not idle
//   frame_done   one-cycle pulse after the last bit period completes
// ---------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int WIDTH = 32,
    parameter int DIV   = 2,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_data,
    output logic             serial_clk,
    output logic             frame_sync,
    output logic             busy,
    output logic             frame_done
);

    localparam int BIT_W   = $clog2(WIDTH + 1);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_CYC = GAP * 2 * DIV;
    localparam int GAP_W   = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    // Only reached when GAP_CYC > 0; the zero case never enters S_GAP.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shreg_shifted;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             sdata_q, sdata_d;
    logic             sclk_q, sclk_d;
    logic             sync_q, sync_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

    assign in_ready      = (state_q == S_IDLE) && !rst;
    assign accept        = in_valid && in_ready;
    assign shreg_shifted = shreg_q << 1;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sdata_d   = sdata_q;
        sclk_d    = sclk_q;
        sync_d    = sync_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                sdata_d = 1'b0;
                sclk_d  = 1'b0;
                sync_d  = 1'b0;
                if (accept) begin
                    state_d   = S_SHIFT;
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    sdata_d   = in_data[WIDTH-1];
                    sync_d    = 1'b1;
                end
            end

            S_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising serial edge: data is held so it is stable
                        // across the receiver's sampling point.
                        sclk_d = 1'b1;
                    end else begin
                        // Falling serial edge closes the current bit period.
                        sclk_d = 1'b0;
                        sync_d = 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            sdata_d   = 1'b0;
                            done_d    = 1'b1;
                            gap_cnt_d = '0;
                            state_d   = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                        end else begin
                            shreg_d   = shreg_shifted;
                            sdata_d   = shreg_shifted[WIDTH-1];
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                sdata_d = 1'b0;
                sclk_d  = 1'b0;
                sync_d  = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                sdata_d = 1'b0;
                sclk_d  = 1'b0;
                sync_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            gap_cnt_q <= '0;
            sdata_q   <= 1'b0;
            sclk_q    <= 1'b0;
            sync_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sdata_q   <= sdata_d;
            sclk_q    <= sclk_d;
            sync_q    <= sync_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign serial_data = sdata_q;
    assign serial_clk  = sclk_q;
    assign frame_sync  = sync_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Three transmitter lanes with different geometries:
//   lane 0: WIDTH=32 DIV=2 GAP=1
//   lane 1: WIDTH=8  DIV=1 GAP=0
//   lane 2: WIDTH=1  DIV=3 GAP=2
// The driver predicts each accept cycle from the frame-period arithmetic and
// pushes {word, accept cycle} into a per-lane queue. A single monitor process
// reassembles bits on serial_clk rising edges and pops/compares whenever a
// lane pulses frame_done; it also checks handshake/idle behaviour each cycle.
// ---------------------------------------------------------------------------
module tb_serial_frame_tx;

    localparam int NL = 3;
    localparam int QD = 16;

    function automatic int lane_w(input int l);
        case (l)
            0:       return 32;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int lane_div(input int l);
        case (l)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int lane_gap(input int l);
        case (l)
            0:       return 1;
            1:       return 0;
            default: return 2;
        endcase
    endfunction

    logic        clk;
    logic        rst;
    logic [31:0] in_data_v  [NL];
    logic        in_valid_v [NL];
    logic        in_ready_v [NL];
    logic        sd_v       [NL];
    logic        sck_v      [NL];
    logic        fs_v       [NL];
    logic        busy_v     [NL];
    logic        fd_v       [NL];

    int cyc = 0;

    // Driver-owned model state
    logic [31:0] exp_w  [NL][QD];
    int          exp_t  [NL][QD];
    int          wr     [NL];
    int          free_c [NL];
    int          last_t [NL];
    logic        end_req;

    // Monitor-owned state
    logic [31:0] rx         [NL];
    int          nbits      [NL];
    int          nsync      [NL];
    int          sync_first [NL];
    int          rd         [NL];
    logic        prev_sck   [NL];
    logic        rst_prev = 1'b0;
    logic        end_ack  = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        localparam int W = lane_w(gi);
        serial_frame_tx #(
            .WIDTH(W),
            .DIV  (lane_div(gi)),
            .GAP  (lane_gap(gi))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_data    (in_data_v[gi][W-1:0]),
            .in_valid   (in_valid_v[gi]),
            .in_ready   (in_ready_v[gi]),
            .serial_data(sd_v[gi]),
            .serial_clk (sck_v[gi]),
            .frame_sync (fs_v[gi]),
            .busy       (busy_v[gi]),
            .frame_done (fd_v[gi])
        );
    end

    task automatic chk(input string name, input int l, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d cycle %0d: got %0h, expected %0h", name, l, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ monitor
    always @(negedge clk) begin : mon
        int          w, d, t;
        logic [31:0] mask;
        logic        busy_exp, in_shift;
        for (int l = 0; l < NL; l++) begin
            w    = lane_w(l);
            d    = lane_div(l);
            mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
            if (rst) begin
                chk("in_ready_in_reset", l, longint'(in_ready_v[l]), 0);
                rd[l]         = wr[l];
                nbits[l]      = 0;
                nsync[l]      = 0;
                sync_first[l] = -1;
            end else begin
                if (rst_prev)
                    chk("post_reset_outputs", l,
                        longint'({sd_v[l], sck_v[l], fs_v[l], busy_v[l], fd_v[l]}), 0);
                busy_exp = (cyc > last_t[l]) && (cyc < free_c[l]);
                in_shift = (cyc > last_t[l]) && (cyc <= last_t[l] + 2 * d * w);
                chk("in_ready", l, longint'(in_ready_v[l]), longint'(!busy_exp));
                chk("busy", l, longint'(busy_v[l]), longint'(busy_exp));
                if (!in_shift)
                    chk("idle_lines", l, longint'({sd_v[l], sck_v[l], fs_v[l]}), 0);
                if (sck_v[l] && !prev_sck[l]) begin
                    rx[l]    = {rx[l][30:0], sd_v[l]};
                    nbits[l] = nbits[l] + 1;
                end
                if (fs_v[l]) begin
                    if (nsync[l] == 0) sync_first[l] = cyc;
                    nsync[l] = nsync[l] + 1;
                end
                if (fd_v[l]) begin
                    if (rd[l] == wr[l]) begin
                        chk("unexpected_frame_done", l, 1, 0);
                    end else begin
                        t = exp_t[l][rd[l] % QD];
                        chk("rx_word", l, longint'(rx[l] & mask), longint'(exp_w[l][rd[l] % QD] & mask));
                        chk("bit_count", l, nbits[l], w);
                        chk("sync_start", l, sync_first[l], t + 1);
                        chk("sync_len", l, nsync[l], 2 * d);
                        chk("done_cycle", l, cyc, t + 1 + 2 * d * w);
                        rd[l] = rd[l] + 1;
                    end
                    nbits[l]      = 0;
                    nsync[l]      = 0;
                    sync_first[l] = -1;
                end
            end
            prev_sck[l] = sck_v[l];
        end
        if (end_req && !end_ack) begin
            for (int l = 0; l < NL; l++) chk("queue_drained", l, wr[l] - rd[l], 0);
            end_ack = 1'b1;
        end
        rst_prev = rst;
    end

    // ------------------------------------------------------------------ driver
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            free_c[l] = 0;
            last_t[l] = -1;
        end
    endtask

    // Present a word and hold it until accepted. keep=1 leaves in_valid high
    // afterwards so the next send follows back-to-back.
    task automatic send(input int l, input logic [31:0] w, input bit keep);
        int t_pred;
        int guard;
        in_data_v[l]  = w;
        in_valid_v[l] = 1'b1;
        t_pred = (cyc > free_c[l]) ? cyc : free_c[l];
        guard  = 0;
        while (!in_ready_v[l]) begin
            step();
            guard++;
            if (guard > 2000) begin
                $display("FAIL accept_timeout lane%0d: no in_ready within 2000 cycles", l);
                $fatal(1, "accept timeout");
            end
        end
        exp_w[l][wr[l] % QD] = w;
        exp_t[l][wr[l] % QD] = t_pred;
        wr[l]     = wr[l] + 1;
        last_t[l] = t_pred;
        free_c[l] = t_pred + 1 + 2 * lane_div(l) * (lane_w(l) + lane_gap(l));
        step();
        if (!keep) begin
            in_valid_v[l] = 1'b0;
            in_data_v[l]  = $urandom;
        end
    endtask

    // Toggle in_valid and in_data randomly while the lane is busy.
    task automatic noise(input int l);
        while (cyc < free_c[l]) begin
            in_valid_v[l] = 1'($urandom_range(0, 1));
            in_data_v[l]  = $urandom;
            step();
        end
        in_valid_v[l] = 1'b0;
    endtask

    task automatic wait_idle(input int l);
        while (cyc < free_c[l]) step();
    endtask

    initial begin
        int t0;
        rst     = 1'b1;
        end_req = 1'b0;
        for (int l = 0; l < NL; l++) begin
            in_valid_v[l] = 1'b0;
            in_data_v[l]  = '0;
            wr[l]         = 0;
        end
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Lane 0 directed
        send(0, 32'hA5C3_0F81, 1'b0);
        wait_idle(0);
        repeat (3) step();
        send(0, 32'h0000_0001, 1'b1);
        send(0, 32'hFFFF_FFFF, 1'b0);
        send(0, 32'h3C3C_55AA, 1'b0);
        noise(0);
        wait_idle(0);

        // Reset mid-frame, 40 cycles after the accept
        send(0, 32'hCAFE_F00D, 1'b0);
        t0 = last_t[0];
        while (cyc < t0 + 40) step();
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        repeat (2) step();
        send(0, 32'h1234_5678, 1'b0);
        wait_idle(0);

        // Lane 1 directed
        send(1, 32'h0000_0096, 1'b0);
        wait_idle(1);
        send(1, 32'h0000_005A, 1'b1);
        send(1, 32'h0000_00C3, 1'b0);
        noise(1);
        wait_idle(1);

        // Lane 2 directed (single-bit frames)
        send(2, 32'h1, 1'b1);
        send(2, 32'h0, 1'b1);
        send(2, 32'h1, 1'b0);
        noise(2);
        wait_idle(2);

        // Randomized traffic per lane
        for (int l = 0; l < NL; l++) begin
            for (int k = 0; k < 8; k++) begin
                bit keep;
                keep = (k < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
                send(l, $urandom, keep);
                if (!keep) begin
                    if ($urandom_range(0, 1) == 1) noise(l);
                    repeat ($urandom_range(0, 3)) step();
                end
            end
            wait_idle(l);
        end

        repeat (4) step();
        end_req = 1'b1;
        for (int g = 0; g < 10 && !end_ack; g++) step();
        if (!end_ack) begin
            $display("FAIL end_check: monitor did not acknowledge end of test");
            $fatal(1, "end check timeout");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Host-side serial frame transmitter that produces the serial_data / serial_clk / frame_sync stream consumed by the accelerator's input deserializers for the A and B operand streams. It accepts one WIDTH-bit parallel word through a valid/ready handshake and shifts it out MSB first on a divided serial clock. It marks the first bit with frame_sync, inserts a programmable idle gap, and then accepts the next word. One instance drives each operand lane in testbenches and in the host-link wrapper.

## Interface

Parameters:
- WIDTH, default 32: frame length in bits (AW*K for one operand row/column); must be ≥1.
- DIV, default 2: clk cycles per serial_clk half-period; must be ≥1.
- GAP, default 1: idle serial_clk periods between frames; must be ≥0.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  WIDTH  parallel word; sampled only on an accept.
- in_valid  in  1  source has a word.
- in_ready  out  1  transmitter can accept; accept occurs when in_valid && in_ready.
- serial_data  out  1  serial bit, MSB first.
- serial_clk  out  1  generated serial clock; the receiver samples on its rising edge.
- frame_sync  out  1  high for exactly the first bit period of a frame.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse after the last bit period completes.

## Operation

- One clock and one synchronous active-high reset, as already decided. All outputs except in_ready are registered.
- States:
  - IDLE: in_ready=1, and serial_clk, serial_data and frame_sync are all 0.
  - SHIFT: the word is being transmitted.
  - GAP: lines are idle, in_ready=0.
- IDLE→SHIFT on accept:
  - Latch in_data into the shift register.
  - Clear the bit counter and the divider counter.
  - Drive serial_data=in_data[WIDTH-1] and frame_sync=1; serial_clk stays 0.
- SHIFT:
  - The divider counts 0..DIV-1 and toggles serial_clk when it wraps.
  - On each 0→1 toggle: no data change. The bit is stable across the receiver's sampling edge.
  - On each 1→0 toggle, if bits remain: shift left, present the next bit, increment the bit counter, and force frame_sync=0.
  - On the 1→0 toggle ending bit WIDTH-1: serial_data=0, serial_clk=0, pulse frame_done. Go to GAP, or to IDLE if GAP=0.
- GAP: count GAP*2*DIV clk cycles with all lines low, then go to IDLE.
- in_ready = (state==IDLE) && !rst (combinational).
- in_data and in_valid are ignored outside IDLE. A word held valid while busy is accepted on the first IDLE cycle.
- Width rules:
  - Bit counter is $clog2(WIDTH+1) bits.
  - Divider counter is $clog2(DIV) bits, minimum 1.
  - Gap counter is $clog2(GAP*2*DIV+1) bits, minimum 1.

## Timing

- Reset: every output is 0 in the cycle after rst is sampled high. in_ready is 0 while rst=1 and 1 in the first cycle after release.
- Accept at cycle T:
  - Bit i (i=0 is the MSB) is valid on serial_data for cycles T+1+2·DIV·i through T+2·DIV·(i+1).
  - serial_clk is high for cycles T+1+2·DIV·i+DIV through T+2·DIV·(i+1).
  - frame_sync is high for cycles T+1 through T+2·DIV.
- frame_done is high only in cycle T+1+2·DIV·WIDTH.
- Earliest next accept is cycle T+1+2·DIV·(WIDTH+GAP). The frame period is 2·DIV·(WIDTH+GAP)+1 cycles.
- WIDTH=1: frame_sync and frame_done behave per the formulas above, with one bit period.
- Reset mid-frame (any state): abort. Outputs go to 0 the next cycle and frame_done is not pulsed. Afterwards the block is in IDLE and the shift contents are discarded.
- in_valid may drop at any time while not accepted; there is no requirement to hold it.

## Test plan

- WIDTH=32, DIV=2, GAP=1, accept 0xA5C3_0F81 at T:
  - Sample serial_data on the rising edges of serial_clk and reassemble 0xA5C3_0F81.
  - frame_sync is high for cycles T+1..T+4.
  - frame_done is high at T+129.
  - in_ready returns at T+133.
- Back-to-back: hold in_valid with 0x0000_0001 then 0xFFFF_FFFF.
  - The second accept occurs exactly 133 cycles after the first.
  - Both words are received intact, with exactly one frame_sync per frame.
- DIV=1, GAP=0, WIDTH=8, data 0x96:
  - serial_clk toggles every cycle.
  - frame_done is at T+17, and in_ready is 1 at T+17.
- Reset at T+40 mid-frame (defaults):
  - All outputs are 0 at T+41 and no frame_done appears.
  - A subsequent accept of 0x1234_5678 transmits correctly.
- Change in_data and pulse in_valid while busy: the transmitted word is unchanged and no extra frame is started.
- Loopback into the team's deserializer (WIDTH=32): send 0xDEAD_BEEF → parallel_data=0xDEAD_BEEF with data_valid asserted once per frame.
